// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM pipeline stage and the
// data memory (or its arbiter).
//   master : drives dmem_req/we/addr/be/wdata and receives dmem_ack/rdata
//   slave  : the memory side
// dmem_addr is word-aligned, dmem_be selects byte lanes, and dmem_wdata carries
// the store data replicated across the lanes.
interface mem_access_stage_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: consumes the EX/MEM register, performs the data-memory
// load/store over a req/ack bus and produces the MEM/WB register contents.
// All registers update on the falling edge of clk like the other pipeline regs.
// Ports:
//   clk, rst_n            pipeline clock (negedge), async active-low reset
//   valid_mem .. pc_p_4_mem  EX/MEM register contents
//   dmem                  data-memory bus (master side)
//   stall_mem             holds EX/MEM and earlier stages while an access is open
//   *_wb                  MEM/WB register contents, with fault flags
// A bus access that sees no dmem_ack for TIMEOUT_CYCLES busy cycles is aborted
// and retired as an access fault with rd_wb forced to 0.
module mem_access_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_mem,
  input  logic            mem_read_mem,
  input  logic            mem_write_mem,
  input  logic [2:0]      funct3_mem,
  input  logic [XLEN-1:0] alu_result_mem,
  input  logic [XLEN-1:0] rs2_data_mem,
  input  logic [4:0]      rd_mem,
  input  logic [XLEN-1:0] pc_p_4_mem,
  mem_access_stage_if.master dmem,
  output logic            stall_mem,
  output logic            valid_wb,
  output logic [XLEN-1:0] load_data_wb,
  output logic [XLEN-1:0] alu_result_wb,
  output logic [4:0]      rd_wb,
  output logic [XLEN-1:0] pc_p_4_wb,
  output logic            misalign_wb,
  output logic            access_fault_wb
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CW-1:0]   tcnt;

  // Copy of the instruction taken when the request is issued, so completion
  // does not depend on the upstream holding its outputs.
  logic            p_write;
  logic [2:0]      p_funct3;
  logic [1:0]      p_lo;
  logic [XLEN-1:0] p_alu;
  logic [4:0]      p_rd;
  logic [XLEN-1:0] p_pc;

  logic            is_mem;
  logic            legal;
  logic            misal;
  logic            go;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_val;
  logic            timeout;

  always_comb begin
    is_mem = valid_mem & (mem_read_mem | mem_write_mem);

    case (funct3_mem)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~mem_write_mem;  // unsigned forms are load-only
      default:                legal = 1'b0;
    endcase

    misal = ((funct3_mem[1:0] == 2'b01) & alu_result_mem[0]) |
            ((funct3_mem[1:0] == 2'b10) & (|alu_result_mem[1:0]));

    go = is_mem & legal & ~misal;

    case (funct3_mem[1:0])
      2'b00: begin
        be_next    = 4'b0001 << alu_result_mem[1:0];
        wdata_next = {(XLEN/8){rs2_data_mem[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << alu_result_mem[1:0];
        wdata_next = {(XLEN/16){rs2_data_mem[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = rs2_data_mem;
      end
    endcase

    ld_b = dmem.dmem_rdata[{p_lo, 3'b000} +: 8];
    ld_h = p_lo[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (p_funct3)
      3'b000:  ld_val = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_b};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_val = dmem.dmem_rdata;
    endcase

    timeout = (tcnt == CW'(TIMEOUT_CYCLES - 1));

    // In BUSY the stall releases in the ack cycle so upstream advances on the
    // same edge that retires the access; a timeout cycle still stalls.
    if (state == IDLE) stall_mem = rst_n & go;
    else               stall_mem = rst_n & ~dmem.dmem_ack;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      tcnt            <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      p_write         <= 1'b0;
      p_funct3        <= '0;
      p_lo            <= '0;
      p_alu           <= '0;
      p_rd            <= '0;
      p_pc            <= '0;
      valid_wb        <= 1'b0;
      load_data_wb    <= '0;
      alu_result_wb   <= '0;
      rd_wb           <= '0;
      pc_p_4_wb       <= '0;
      misalign_wb     <= 1'b0;
      access_fault_wb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (go) begin
            state           <= BUSY;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= mem_write_mem;
            dmem.dmem_addr  <= {alu_result_mem[XLEN-1:2], 2'b00};
            dmem.dmem_be    <= be_next;
            dmem.dmem_wdata <= wdata_next;
            p_write         <= mem_write_mem;
            p_funct3        <= funct3_mem;
            p_lo            <= alu_result_mem[1:0];
            p_alu           <= alu_result_mem;
            p_rd            <= rd_mem;
            p_pc            <= pc_p_4_mem;
            valid_wb        <= 1'b0;
            load_data_wb    <= '0;
            alu_result_wb   <= '0;
            rd_wb           <= '0;
            pc_p_4_wb       <= '0;
            misalign_wb     <= 1'b0;
            access_fault_wb <= 1'b0;
          end else if (is_mem) begin
            valid_wb        <= 1'b1;
            load_data_wb    <= '0;
            alu_result_wb   <= alu_result_mem;
            rd_wb           <= '0;
            pc_p_4_wb       <= pc_p_4_mem;
            misalign_wb     <= legal & misal;
            access_fault_wb <= ~legal;
          end else begin
            valid_wb        <= valid_mem;
            load_data_wb    <= '0;
            alu_result_wb   <= alu_result_mem;
            rd_wb           <= rd_mem;
            pc_p_4_wb       <= pc_p_4_mem;
            misalign_wb     <= 1'b0;
            access_fault_wb <= 1'b0;
          end
        end

        BUSY: begin
          if (dmem.dmem_ack || timeout) begin
            state           <= IDLE;
            tcnt            <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_be    <= '0;
            valid_wb        <= 1'b1;
            alu_result_wb   <= p_alu;
            pc_p_4_wb       <= p_pc;
            misalign_wb     <= 1'b0;
            if (dmem.dmem_ack) begin
              load_data_wb    <= p_write ? '0 : ld_val;
              rd_wb           <= p_rd;
              access_fault_wb <= 1'b0;
            end else begin
              load_data_wb    <= '0;
              rd_wb           <= '0;
              access_fault_wb <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_mem, mem_read_mem, mem_write_mem;
  logic [2:0]      funct3_mem;
  logic [XLEN-1:0] alu_result_mem, rs2_data_mem, pc_p_4_mem;
  logic [4:0]      rd_mem;
  logic            stall_mem, valid_wb, misalign_wb, access_fault_wb;
  logic [XLEN-1:0] load_data_wb, alu_result_wb, pc_p_4_wb;
  logic [4:0]      rd_wb;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage_if #(.XLEN(XLEN)) bus ();

  mem_access_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_mem       (valid_mem),
    .mem_read_mem    (mem_read_mem),
    .mem_write_mem   (mem_write_mem),
    .funct3_mem      (funct3_mem),
    .alu_result_mem  (alu_result_mem),
    .rs2_data_mem    (rs2_data_mem),
    .rd_mem          (rd_mem),
    .pc_p_4_mem      (pc_p_4_mem),
    .dmem            (bus),
    .stall_mem       (stall_mem),
    .valid_wb        (valid_wb),
    .load_data_wb    (load_data_wb),
    .alu_result_wb   (alu_result_wb),
    .rd_wb           (rd_wb),
    .pc_p_4_wb       (pc_p_4_wb),
    .misalign_wb     (misalign_wb),
    .access_fault_wb (access_fault_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Registers change on negedge; sample/drive 1 time unit later.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input logic [31:0] pc);
    valid_mem      = v;
    mem_read_mem   = r;
    mem_write_mem  = w;
    funct3_mem     = f3;
    alu_result_mem = a;
    rs2_data_mem   = d;
    rd_mem         = rd;
    pc_p_4_mem     = pc;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  // Runs one accepted access already driven on the inputs; ack comes after
  // 'waits' busy cycles without it (ack in busy cycle waits+1).
  task automatic mem_op(input string tag, input int waits, input logic [31:0] rdata,
                        input logic [31:0] e_addr, input logic e_we,
                        input logic chk_be, input logic [3:0] e_be,
                        input logic chk_wd, input logic [31:0] e_wd,
                        input logic [4:0] e_rd, input logic [31:0] e_ld);
    int st;
    st = 0;
    #1 if (stall_mem) st++;
    for (int k = 0; k <= waits; k++) begin
      step();
      check({tag, ".req"}, bus.dmem_req, 1'b1);
      check({tag, ".addr"}, bus.dmem_addr, e_addr);
      check({tag, ".we"}, bus.dmem_we, e_we);
      if (chk_be) check({tag, ".be"}, bus.dmem_be, e_be);
      if (chk_wd) check({tag, ".wdata"}, bus.dmem_wdata, e_wd);
      if (k == 0) check({tag, ".bubble"}, valid_wb, 1'b0);
      if (k == waits) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
      end
      #1 if (stall_mem) st++;
    end
    step();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    check({tag, ".stall_cycles"}, st, waits + 1);
    check({tag, ".req_drop"}, bus.dmem_req, 1'b0);
    check({tag, ".valid_wb"}, valid_wb, 1'b1);
    check({tag, ".rd_wb"}, rd_wb, e_rd);
    check({tag, ".load"}, load_data_wb, e_ld);
    check({tag, ".fault"}, {misalign_wb, access_fault_wb}, 2'b00);
    idle_in();
  endtask

  initial begin
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    idle_in();

    // Reset state
    #3;
    check("rst.req", bus.dmem_req, 1'b0);
    check("rst.we", bus.dmem_we, 1'b0);
    check("rst.be", bus.dmem_be, 4'h0);
    check("rst.wb", {valid_wb, rd_wb, misalign_wb, access_fault_wb}, 8'h00);
    check("rst.alu_wb", alu_result_wb, 32'h0);
    check("rst.load_wb", load_data_wb, 32'h0);
    check("rst.stall", stall_mem, 1'b0);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Non-memory instruction
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h104);
    #1 check("alu.stall", stall_mem, 1'b0);
    step();
    check("alu.valid_wb", valid_wb, 1'b1);
    check("alu.alu_wb", alu_result_wb, 32'h1234);
    check("alu.rd_wb", rd_wb, 5'd5);
    check("alu.pc_wb", pc_p_4_wb, 32'h104);
    check("alu.load_wb", load_data_wb, 32'h0);
    check("alu.stall2", stall_mem, 1'b0);
    idle_in();

    // Loads
    drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 5'd7, 32'h108);
    mem_op("lb", 3, 32'h80AABBCC, 32'h1000, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 5'd7, 32'hFFFFFF80);
    drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 5'd8, 32'h10C);
    mem_op("lbu", 3, 32'h80AABBCC, 32'h1000, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 5'd8, 32'h00000080);
    drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 5'd9, 32'h110);
    mem_op("lh", 1, 32'h80AABBCC, 32'h2000, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 5'd9, 32'hFFFF80AA);
    drive(1'b1, 1'b1, 1'b0, 3'b101, 32'h2000, 32'h0, 5'd10, 32'h114);
    mem_op("lhu", 0, 32'h1234F00D, 32'h2000, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 5'd10, 32'h0000F00D);

    // Stores
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h2002, 32'hDEADBEEF, 5'd1, 32'h118);
    mem_op("sh", 2, 32'h0, 32'h2000, 1'b1, 1'b1, 4'b1100, 1'b1, 32'hBEEFBEEF, 5'd1, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h4001, 32'h11223344, 5'd2, 32'h11C);
    mem_op("sb", 0, 32'h0, 32'h4000, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h44444444, 5'd2, 32'h0);
    // read+write together: the write wins
    drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h6000, 32'hCAFEF00D, 5'd4, 32'h120);
    mem_op("sw_rw", 1, 32'h99999999, 32'h6000, 1'b1, 1'b1, 4'b1111, 1'b1, 32'hCAFEF00D, 5'd4, 32'h0);

    // Faults detected at decode
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 5'd9, 32'h124);
    #1 check("mis.stall", stall_mem, 1'b0);
    step();
    check("mis.req", bus.dmem_req, 1'b0);
    check("mis.wb", {valid_wb, rd_wb, misalign_wb, access_fault_wb}, {1'b1, 5'd0, 1'b1, 1'b0});
    drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h3000, 32'h0, 5'd9, 32'h128);
    #1 check("ill_ld.stall", stall_mem, 1'b0);
    step();
    check("ill_ld.req", bus.dmem_req, 1'b0);
    check("ill_ld.wb", {valid_wb, rd_wb, misalign_wb, access_fault_wb}, {1'b1, 5'd0, 1'b0, 1'b1});
    drive(1'b1, 1'b0, 1'b1, 3'b100, 32'h3000, 32'h0, 5'd9, 32'h12C);
    step();
    check("ill_st.wb", {valid_wb, rd_wb, misalign_wb, access_fault_wb}, {1'b1, 5'd0, 1'b0, 1'b1});
    idle_in();

    // Timeout: no ack at all
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h7000, 32'h0, 5'd11, 32'h130);
    #1 check("to.stall0", stall_mem, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      step();
      check($sformatf("to.req_c%0d", k), bus.dmem_req, 1'b1);
      check($sformatf("to.stall_c%0d", k), stall_mem, 1'b1);
    end
    step();
    check("to.req_drop", bus.dmem_req, 1'b0);
    check("to.wb", {valid_wb, rd_wb, misalign_wb, access_fault_wb}, {1'b1, 5'd0, 1'b0, 1'b1});
    check("to.alu_wb", alu_result_wb, 32'h7000);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd3, 32'h134);
    #1 check("to.next_stall", stall_mem, 1'b0);
    step();
    check("to.next_wb", {valid_wb, rd_wb, access_fault_wb}, {1'b1, 5'd3, 1'b0});
    check("to.next_alu", alu_result_wb, 32'h55);
    idle_in();

    // Ack in the final allowed busy cycle completes normally
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h7004, 32'h0, 5'd12, 32'h138);
    mem_op("to_ack16", TO - 1, 32'h0BADF00D, 32'h7004, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 5'd12, 32'h0BADF00D);

    // Reset while busy
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h8000, 32'h0, 5'd13, 32'h13C);
    step();
    step();
    check("rb.req_busy", bus.dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rb.req", bus.dmem_req, 1'b0);
    check("rb.stall", stall_mem, 1'b0);
    check("rb.wb", {valid_wb, rd_wb, misalign_wb, access_fault_wb}, 8'h00);
    check("rb.alu_wb", alu_result_wb, 32'h0);
    check("rb.pc_wb", pc_p_4_wb, 32'h0);
    idle_in();
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h12345678;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("rb.late_req", bus.dmem_req, 1'b0);
    check("rb.late_valid", valid_wb, 1'b0);
    check("rb.late_load", load_data_wb, 32'h0);
    check("rb.late_stall", stall_mem, 1'b0);
    bus.dmem_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
